// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: the fetch unit drives the word index and the memory
// returns the instruction word in the same cycle.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and loads the IF/ID
// register, with load-use stall and branch redirect (which flushes IF/ID).
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_pc_plus4,
  output logic                if_id_valid,
  output logic [31:0]         fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4       = pc_q + 32'd4;
  // Index wraps naturally because only the low word-index bits of the PC are used.
  assign imem.imem_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (branch_taken) begin
      // Redirect wins over stall; the word fetched this cycle is on the wrong path.
      pc_d     = {branch_target[31:2], 2'b00};
      instr_d  = NOP_INSTR;
      id_pc_d  = 32'd0;
      id_pc4_d = 32'd0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      pc_d     = pc_plus4;
      instr_d  = imem.imem_data;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      id_pc_q  <= 32'd0;
      id_pc4_q <= 32'd0;
      valid_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = count_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 5-stage pipeline, and the initiating side of the instruction-memory read interface.
- Owns the PC and drives the word index to the instruction memory, which returns the word combinationally in the same cycle.
- Registers the returned instruction, PC and PC+4 into the IF/ID pipeline register.
- Handles decode-stage stall and branch/jump redirect with flush.

Parameters:
- ADDR_W, 2, instruction-memory word-index width (memory depth = 2^ADDR_W words)
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTR, 32'h00000000, instruction word inserted on bubble/flush

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  ADDR_W  word index to instruction memory
- imem_data  input  32  instruction word returned combinationally for imem_addr
- stall  input  1  hold request from hazard unit (load-use)
- branch_taken  input  1  redirect request from EX stage
- branch_target  input  32  byte address of redirect target
- if_id_instr  output  32  registered instruction to decode
- if_id_pc  output  32  byte PC of if_id_instr
- if_id_pc_plus4  output  32  if_id_pc + 4
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- fetch_count  output  32  number of instructions delivered with valid=1

Behaviour:
- Reset (async, immediate, independent of clk):
  - pc = RESET_PC
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_pc_plus4 = 0, if_id_valid = 0, fetch_count = 0
  - Reset asserted mid-operation discards all in-flight state.
  - First real fetch occurs on the first rising edge after reset deasserts.
- imem_addr = pc[ADDR_W+1:2], combinational from the PC register. Addresses wrap modulo memory depth, e.g. with ADDR_W=2, pc=16 gives index 0.
- Per rising edge, in priority order:
  1. branch_taken=1 (overrides stall):
     - pc <= {branch_target[31:2], 2'b00}; low two target bits are ignored.
     - IF/ID <= bubble: instr=NOP_INSTR, valid=0, pc and pc_plus4 = 0.
     - fetch_count unchanged.
  2. stall=1, branch_taken=0:
     - pc and all IF/ID outputs hold.
     - fetch_count holds.
     - imem_addr stays constant.
  3. Otherwise:
     - if_id_instr <= imem_data, if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_valid <= 1
     - pc <= pc+4
     - fetch_count <= fetch_count+1
- Arithmetic:
  - pc+4 is 32-bit modulo, so 32'hFFFFFFFC advances to 32'h00000000 with no error flag.
  - fetch_count wraps modulo 2^32.
- Latency: the instruction at PC p appears on if_id_* one cycle after pc=p, given no stall or branch in that cycle.
- Repeated stall: arbitrary length; on release, fetch resumes at the held PC with no instruction lost or duplicated.
- Branch target equal to the current PC is legal: bubble, then refetch of the same word.
- No internal state machine beyond the PC/IF-ID registers; the three per-cycle modes above are exhaustive.

Test Plan:
- Bench instruction memory: 4-word ROM with [0]=32'h00011000, [1]=32'h00000001, [2]=32'h00000003, [3]=32'h00000007.
- Reset then 4 free-running edges:
  - if_id_instr sequence 00011000, 00000001, 00000003, 00000007
  - if_id_pc sequence 0, 4, 8, 12
  - if_id_valid=1 from first edge; fetch_count=4
- Continue 2 more edges: pc wraps the index, if_id_instr 00011000 then 00000001 with if_id_pc 16, 20, imem_addr 0 then 1.
- Stall 3 cycles while if_id_pc=4:
  - outputs frozen at 00000001/4, fetch_count frozen
  - on release, next if_id_instr=00000003 with if_id_pc=8
- branch_taken=1 with branch_target=32'h0000000D while stall=1:
  - next edge: if_id_valid=0, if_id_instr=0
  - pc=12; following edge if_id_instr=00000007, if_id_pc=12
- Load pc=32'hFFFFFFFC via branch, one free edge: if_id_pc=FFFFFFFC, if_id_pc_plus4=0, next pc=0.
- Assert reset asynchronously mid-cycle after 5 fetches: outputs clear before the next edge, fetch_count=0; first post-reset fetch returns 00011000 at pc 0.
